// File: rtl/alu_pkg.sv
// ALU operation classes used between the main controller and ALU control.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_BRANCH = 2'd1,
      ALU_RTYPE  = 2'd2,
      ALU_ITYPE  = 2'd3
   } alu_op_sel_t;

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath bundle: instruction fields in, control strobes out.
interface mips_controller_if;
   import alu_pkg::*;

   logic [5:0]  ir_31_26;
   logic [5:0]  ir_5_to_0;
   logic        branch_taken;
   logic        pc_write_en;
   logic        i_or_d;
   logic        mem_write;
   logic        mem_to_reg;
   logic        ir_write;
   logic        reg_dst;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  pc_source;
   alu_op_sel_t alu_op;
   logic        jump_and_link;
   logic        is_signed;
   logic        halted;
   logic        illegal_op;

   // Controller side
   modport master (
      input  ir_31_26, ir_5_to_0, branch_taken,
      output pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write,
             alu_src_a, alu_src_b, pc_source, alu_op, jump_and_link, is_signed, halted,
             illegal_op
   );

   // Datapath side
   modport slave (
      output ir_31_26, ir_5_to_0, branch_taken,
      input  pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write,
             alu_src_a, alu_src_b, pc_source, alu_op, jump_and_link, is_signed, halted,
             illegal_op
   );
endinterface

// File: rtl/mips_controller.sv
// Multi-cycle MIPS control FSM: one instruction phase per state, Moore-style
// strobes plus a conditional PC write in BRANCH.
module mips_controller
   import alu_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
   input  logic                clk,
   input  logic                rst,
   mips_controller_if.master   ctrl_bus
);

   typedef enum logic [3:0] {
      StFetch, StFetchWait, StDecode, StRExec, StRWb, StIExec, StIWb, StMemAddr,
      StLwRead, StLwWait, StLwWb, StSwWrite, StBranch, StJump, StJal, StHalt
   } state_e;

   state_e      r_state;
   state_e      w_state_next;

   logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_write, w_mem_to_reg;
   logic        w_ir_write, w_reg_dst, w_reg_write, w_alu_src_a, w_jump_and_link;
   logic        w_is_signed, w_halted, w_illegal_op, w_zext;
   logic [1:0]  w_alu_src_b, w_pc_source;
   alu_op_sel_t w_alu_op;

   // Logical immediates (sltiu/andi/ori/xori) take a zero-extended immediate
   assign w_zext = (ctrl_bus.ir_31_26 inside {6'h0B, 6'h0C, 6'h0D, 6'h0E});

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) r_state <= StFetch;
      else      r_state <= w_state_next;
   end

   // Next-state and per-state control decode
   always_comb begin
      w_state_next    = r_state;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_i_or_d        = 1'b0;
      w_mem_write     = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_dst       = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_pc_source     = 2'b00;
      w_alu_op        = ALU_ADD;
      w_jump_and_link = 1'b0;
      w_is_signed     = 1'b1;
      w_halted        = 1'b0;
      w_illegal_op    = 1'b0;
      case (r_state)
         StFetch: begin
            w_i_or_d     = 1'b0;
            w_state_next = StFetchWait;
         end
         StFetchWait: begin
            w_ir_write   = 1'b1;
            w_alu_src_b  = 2'b01;
            w_pc_write   = 1'b1;
            w_state_next = StDecode;
         end
         StDecode: begin
            // Speculative branch target into ALU_OUT
            w_alu_src_b = 2'b11;
            if (ctrl_bus.ir_31_26 == HALT_OPCODE) begin
               w_state_next = StHalt;
            end else begin
               case (ctrl_bus.ir_31_26)
                  6'h00:                      w_state_next = StRExec;
                  6'h23, 6'h2B:               w_state_next = StMemAddr;
                  6'h01, 6'h04, 6'h05,
                  6'h06, 6'h07:               w_state_next = StBranch;
                  6'h02:                      w_state_next = StJump;
                  6'h03:                      w_state_next = StJal;
                  6'h09, 6'h0A, 6'h0B, 6'h0C,
                  6'h0D, 6'h0E, 6'h10:        w_state_next = StIExec;
                  default: begin
                     w_illegal_op = 1'b1;
                     w_state_next = StFetch;
                  end
               endcase
            end
         end
         StRExec: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_RTYPE;
            case (ctrl_bus.ir_5_to_0)
               6'h08: begin
                  w_pc_write   = 1'b1;
                  w_state_next = StFetch;
               end
               6'h18, 6'h19: w_state_next = StFetch;
               default:      w_state_next = StRWb;
            endcase
         end
         StRWb: begin
            w_reg_dst    = 1'b1;
            w_reg_write  = 1'b1;
            w_alu_op     = ALU_RTYPE;
            w_state_next = StFetch;
         end
         StIExec: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'b10;
            w_alu_op     = ALU_ITYPE;
            w_is_signed  = ~w_zext;
            w_state_next = StIWb;
         end
         StIWb: begin
            w_reg_write  = 1'b1;
            w_alu_op     = ALU_ITYPE;
            w_is_signed  = ~w_zext;
            w_state_next = StFetch;
         end
         StMemAddr: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'b10;
            w_state_next = (ctrl_bus.ir_31_26 == 6'h2B) ? StSwWrite : StLwRead;
         end
         StLwRead: begin
            w_i_or_d     = 1'b1;
            w_state_next = StLwWait;
         end
         StLwWait: begin
            w_i_or_d     = 1'b1;
            w_state_next = StLwWb;
         end
         StLwWb: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_state_next = StFetch;
         end
         StSwWrite: begin
            w_i_or_d     = 1'b1;
            w_mem_write  = 1'b1;
            w_state_next = StFetch;
         end
         StBranch: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = ALU_BRANCH;
            w_pc_source     = 2'b01;
            w_pc_write_cond = 1'b1;
            w_state_next    = StFetch;
         end
         StJump: begin
            w_pc_source  = 2'b10;
            w_pc_write   = 1'b1;
            w_state_next = StFetch;
         end
         StJal: begin
            w_pc_source     = 2'b10;
            w_pc_write      = 1'b1;
            w_jump_and_link = 1'b1;
            w_reg_write     = 1'b1;
            w_state_next    = StFetch;
         end
         StHalt: begin
            w_halted     = 1'b1;
            w_state_next = StHalt;
         end
         default: w_state_next = StFetch;
      endcase
   end

   // Outputs forced low while reset is held
   always_comb begin
      ctrl_bus.pc_write_en   = rst & (w_pc_write | (w_pc_write_cond & ctrl_bus.branch_taken));
      ctrl_bus.i_or_d        = rst & w_i_or_d;
      ctrl_bus.mem_write     = rst & w_mem_write;
      ctrl_bus.mem_to_reg    = rst & w_mem_to_reg;
      ctrl_bus.ir_write      = rst & w_ir_write;
      ctrl_bus.reg_dst       = rst & w_reg_dst;
      ctrl_bus.reg_write     = rst & w_reg_write;
      ctrl_bus.alu_src_a     = rst & w_alu_src_a;
      ctrl_bus.alu_src_b     = rst ? w_alu_src_b : 2'b00;
      ctrl_bus.pc_source     = rst ? w_pc_source : 2'b00;
      ctrl_bus.alu_op        = rst ? w_alu_op : ALU_ADD;
      ctrl_bus.jump_and_link = rst & w_jump_and_link;
      ctrl_bus.is_signed     = rst & w_is_signed;
      ctrl_bus.halted        = rst & w_halted;
      ctrl_bus.illegal_op    = rst & w_illegal_op;
   end

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: per-instruction phase lists drive a reference
// control-word model, checked every cycle against the DUT.
module tb_mips_controller;
   import alu_pkg::*;

   typedef struct packed {
      logic       pc_write_en;
      logic       i_or_d;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       jump_and_link;
      logic       is_signed;
      logic       halted;
      logic       illegal_op;
   } ctl_t;

   localparam int PhF = 0, PhFw = 1, PhD = 2, PhRex = 3, PhRwb = 4, PhIex = 5, PhIwb = 6;
   localparam int PhMa = 7, PhLr = 8, PhLw = 9, PhLwb = 10, PhSw = 11, PhBr = 12;
   localparam int PhJ = 13, PhJal = 14, PhH = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   mips_controller_if bus ();

   mips_controller #(.HALT_OPCODE(6'h3F)) dut (
      .clk      (clk),
      .rst      (rst),
      .ctrl_bus (bus)
   );

   always #5 clk = ~clk;

   function automatic ctl_t observed();
      ctl_t o;
      o.pc_write_en   = bus.pc_write_en;
      o.i_or_d        = bus.i_or_d;
      o.mem_write     = bus.mem_write;
      o.mem_to_reg    = bus.mem_to_reg;
      o.ir_write      = bus.ir_write;
      o.reg_dst       = bus.reg_dst;
      o.reg_write     = bus.reg_write;
      o.alu_src_a     = bus.alu_src_a;
      o.alu_src_b     = bus.alu_src_b;
      o.pc_source     = bus.pc_source;
      o.alu_op        = bus.alu_op;
      o.jump_and_link = bus.jump_and_link;
      o.is_signed     = bus.is_signed;
      o.halted        = bus.halted;
      o.illegal_op    = bus.illegal_op;
      return o;
   endfunction

   function automatic bit is_legal(logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2B, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02,
                        6'h03, 6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h3F};
   endfunction

   // Reference control word for one instruction phase
   function automatic ctl_t expect_word(int ph, logic [5:0] op, logic [5:0] fn, logic bt);
      ctl_t w = '0;
      w.is_signed = 1'b1;
      w.alu_op    = ALU_ADD;
      case (ph)
         PhFw: begin w.ir_write = 1; w.alu_src_b = 2'b01; w.pc_write_en = 1; end
         PhD:  begin w.alu_src_b = 2'b11; w.illegal_op = !is_legal(op); end
         PhRex: begin
            w.alu_src_a = 1; w.alu_op = ALU_RTYPE;
            w.pc_write_en = (fn == 6'h08);
         end
         PhRwb: begin w.reg_dst = 1; w.reg_write = 1; w.alu_op = ALU_RTYPE; end
         PhIex: begin
            w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_op = ALU_ITYPE;
            w.is_signed = !(op inside {6'h0B, 6'h0C, 6'h0D, 6'h0E});
         end
         PhIwb: begin
            w.reg_write = 1; w.alu_op = ALU_ITYPE;
            w.is_signed = !(op inside {6'h0B, 6'h0C, 6'h0D, 6'h0E});
         end
         PhMa:  begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
         PhLr, PhLw: w.i_or_d = 1;
         PhLwb: begin w.mem_to_reg = 1; w.reg_write = 1; end
         PhSw:  begin w.i_or_d = 1; w.mem_write = 1; end
         PhBr: begin
            w.alu_src_a = 1; w.alu_op = ALU_BRANCH; w.pc_source = 2'b01;
            w.pc_write_en = bt;
         end
         PhJ:   begin w.pc_source = 2'b10; w.pc_write_en = 1; end
         PhJal: begin
            w.pc_source = 2'b10; w.pc_write_en = 1; w.jump_and_link = 1; w.reg_write = 1;
         end
         PhH:   w.halted = 1;
         default: ;
      endcase
      return w;
   endfunction

   task automatic chk(input string tag, input ctl_t obs, input ctl_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Run one instruction; abort_at >= 0 pulls reset low in that phase index
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
      int   seq[$];
      logic bt;
      seq = {PhF, PhFw, PhD};
      if (op == 6'h3F) seq.push_back(PhH);
      else if (op == 6'h00) begin
         seq.push_back(PhRex);
         if (!(fn inside {6'h08, 6'h18, 6'h19})) seq.push_back(PhRwb);
      end
      else if (op == 6'h23) seq = {seq, PhMa, PhLr, PhLw, PhLwb};
      else if (op == 6'h2B) seq = {seq, PhMa, PhSw};
      else if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) seq.push_back(PhBr);
      else if (op == 6'h02) seq.push_back(PhJ);
      else if (op == 6'h03) seq.push_back(PhJal);
      else if (is_legal(op)) seq = {seq, PhIex, PhIwb};
      foreach (seq[k]) begin
         bt = 1'($urandom);
         bus.ir_31_26     = op;
         bus.ir_5_to_0    = fn;
         bus.branch_taken = bt;
         rst = (k == abort_at) ? 1'b0 : 1'b1;
         #1;
         if (k == abort_at)
            chk($sformatf("abort op%02h ph%0d", op, k), observed(), '0);
         else
            chk($sformatf("op%02h fn%02h ph%0d", op, fn, k), observed(),
                expect_word(seq[k], op, fn, bt));
         @(posedge clk);
         #1;
         if (k == abort_at) break;
      end
      rst = 1'b1;
   endtask

   logic [5:0] legal_ops[17] = '{6'h00, 6'h23, 6'h2B, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h02, 6'h03, 6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                 6'h0E};
   logic [5:0] fns[5] = '{6'h21, 6'h08, 6'h18, 6'h19, 6'h2A};

   initial begin
      logic [5:0] op, fn;
      // Reset held for two edges: everything low
      bus.ir_31_26 = 6'h00; bus.ir_5_to_0 = 6'h21; bus.branch_taken = 1'b1;
      rst = 1'b0;
      #2 chk("reset0", observed(), '0);
      @(posedge clk); #1;
      bus.ir_31_26 = 6'h3F;
      chk("reset1", observed(), '0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed instructions
      run_instr(6'h00, 6'h21, -1);
      run_instr(6'h00, 6'h18, -1);
      run_instr(6'h00, 6'h08, -1);
      run_instr(6'h23, 6'h00, -1);
      run_instr(6'h2B, 6'h00, -1);
      run_instr(6'h04, 6'h00, -1);
      run_instr(6'h05, 6'h00, -1);
      run_instr(6'h02, 6'h00, -1);
      run_instr(6'h03, 6'h00, -1);
      run_instr(6'h0C, 6'h00, -1);
      run_instr(6'h09, 6'h00, -1);
      run_instr(6'h3A, 6'h00, -1);
      run_instr(6'h23, 6'h00, 5);   // reset during LW_WAIT
      run_instr(6'h00, 6'h21, -1);

      // Randomized instruction mix including illegal opcodes
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            do op = 6'($urandom); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 16)];
         end
         fn = fns[$urandom_range(0, 4)];
         run_instr(op, fn, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
      end

      // Halt: parked for 20 cycles, released only by reset
      run_instr(6'h3F, 6'h00, -1);
      for (int i = 0; i < 20; i++) begin
         bus.ir_31_26     = 6'($urandom);
         bus.branch_taken = 1'($urandom);
         #1 chk($sformatf("halt%0d", i), observed(), expect_word(PhH, 6'h3F, 6'h00, 1'b0));
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1 chk("halt_reset", observed(), '0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_instr(6'h2B, 6'h00, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
